// File: rtl/rgb_color_ctrl_pkg.sv
// Shared definitions for the RGB colour controller: cursor encodings,
// default channel width and the saturating edit helper.
package rgb_color_ctrl_pkg;

  localparam int unsigned DEF_CW = 4;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_sel_t;

  // Returns 1 when an inc/dec request would actually move a value of width cw.
  function automatic logic edit_effective(input logic inc, input logic dec,
                                          input logic [31:0] val, input int unsigned cw);
    logic [31:0] max_v;
    max_v = (32'd1 << cw) - 32'd1;
    if (inc && !dec) return (val != max_v);
    if (dec && !inc) return (val != 32'd0);
    return 1'b0;
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Per-channel PWM generator: prescaler, shared period counter and three
// registered comparators (one cycle of latency from counter/value to LED).
module rgb_pwm #(
  parameter int unsigned CW      = 4,
  parameter int unsigned PWM_DIV = 1000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] val_r,
  input  logic [CW-1:0] val_g,
  input  logic [CW-1:0] val_b,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b
);

  localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_pwm_cnt;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(PWM_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      led_r     <= 1'b0;
      led_g     <= 1'b0;
      led_b     <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      // Natural CW-bit wrap from all-ones back to zero.
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + CW'(1);
      led_r     <= (r_pwm_cnt < val_r);
      led_g     <= (r_pwm_cnt < val_g);
      led_b     <= (r_pwm_cnt < val_b);
    end
  end

endmodule

// File: rtl/rgb_color_ctrl.sv
// RGB colour controller: channel cursor FSM, saturating intensity registers,
// selected-value mux and update pulse, driving the rgb_pwm LED generator.
module rgb_color_ctrl
  import rgb_color_ctrl_pkg::*;
#(
  parameter int unsigned CW      = DEF_CW,
  parameter int unsigned PWM_DIV = 1000,
  parameter int unsigned DEF_R   = 8,
  parameter int unsigned DEF_G   = 8,
  parameter int unsigned DEF_B   = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          sel_p,
  input  logic          inc_p,
  input  logic          dec_p,
  output logic [1:0]    sel_ch,
  output logic [CW-1:0] ch_val,
  output logic          update,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b
);

  ch_sel_t       r_state;
  ch_sel_t       w_state_nxt;
  logic [CW-1:0] r_val_r, r_val_g, r_val_b;
  logic [CW-1:0] w_val_r_nxt, w_val_g_nxt, w_val_b_nxt;
  logic [CW-1:0] w_cur_val;
  logic [CW-1:0] w_new_val;
  logic          w_change;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= CH_R;
      r_val_r <= CW'(DEF_R);
      r_val_g <= CW'(DEF_G);
      r_val_b <= CW'(DEF_B);
      update  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_val_r <= w_val_r_nxt;
      r_val_g <= w_val_g_nxt;
      r_val_b <= w_val_b_nxt;
      update  <= w_change;
    end
  end

  // Edit targets the channel selected before any same-edge cursor step.
  always_comb begin
    w_state_nxt = r_state;
    w_val_r_nxt = r_val_r;
    w_val_g_nxt = r_val_g;
    w_val_b_nxt = r_val_b;
    w_cur_val   = r_val_r;
    w_new_val   = r_val_r;
    w_change    = 1'b0;

    case (r_state)
      CH_G:    w_cur_val = r_val_g;
      CH_B:    w_cur_val = r_val_b;
      default: w_cur_val = r_val_r;
    endcase

    w_change  = edit_effective(inc_p, dec_p, 32'(w_cur_val), CW);
    w_new_val = inc_p ? (w_cur_val + CW'(1)) : (w_cur_val - CW'(1));

    if (w_change) begin
      case (r_state)
        CH_G:    w_val_g_nxt = w_new_val;
        CH_B:    w_val_b_nxt = w_new_val;
        default: w_val_r_nxt = w_new_val;
      endcase
    end

    if (sel_p) begin
      case (r_state)
        CH_R:    w_state_nxt = CH_G;
        CH_G:    w_state_nxt = CH_B;
        default: w_state_nxt = CH_R;
      endcase
    end
  end

  assign sel_ch = 2'(r_state);
  assign ch_val = w_cur_val;

  rgb_pwm #(
    .CW      (CW),
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk   (clk),
    .rstn  (rstn),
    .val_r (r_val_r),
    .val_g (r_val_g),
    .val_b (r_val_b),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b)
  );

endmodule

// File: tb/tb_rgb_color_ctrl.sv
// Self-checking bench for rgb_color_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_rgb_color_ctrl;

  localparam int unsigned CW   = 4;
  localparam int          VMAX = 15;
  localparam int          PER  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sel_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
  logic [1:0]    sel_ch;
  logic [CW-1:0] ch_val;
  logic          update, led_r, led_g, led_b;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state.
  int m_val[3];
  int m_sel;
  int m_phase;
  bit m_upd;
  bit m_led[3];
  bit m_valid = 1'b0;

  rgb_color_ctrl #(.CW(CW), .PWM_DIV(1), .DEF_R(8), .DEF_G(8), .DEF_B(8)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sel_p  (sel_p),
    .inc_p  (inc_p),
    .dec_p  (dec_p),
    .sel_ch (sel_ch),
    .ch_val (ch_val),
    .update (update),
    .led_r  (led_r),
    .led_g  (led_g),
    .led_b  (led_b)
  );

  always #5 clk = ~clk;

  // Model: LED shows where the period was last cycle relative to last cycle's value.
  always @(posedge clk) begin
    if (!rstn) begin
      m_val   = '{8, 8, 8};
      m_sel   = 0;
      m_phase = 0;
      m_upd   = 1'b0;
      m_led   = '{1'b0, 1'b0, 1'b0};
      m_valid = 1'b1;
    end else begin
      for (int c = 0; c < 3; c++) m_led[c] = (m_phase < m_val[c]);
      m_phase = (m_phase + 1) % PER;
      m_upd   = 1'b0;
      if (inc_p && !dec_p && m_val[m_sel] < VMAX) begin
        m_val[m_sel] = m_val[m_sel] + 1;
        m_upd = 1'b1;
      end else if (dec_p && !inc_p && m_val[m_sel] > 0) begin
        m_val[m_sel] = m_val[m_sel] - 1;
        m_upd = 1'b1;
      end
      if (sel_p) m_sel = (m_sel + 1) % 3;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("sel_ch", int'(sel_ch), m_sel);
      chk("ch_val", int'(ch_val), m_val[m_sel]);
      chk("update", int'(update), int'(m_upd));
      chk("led_r", int'(led_r), int'(m_led[0]));
      chk("led_g", int'(led_g), int'(m_led[1]));
      chk("led_b", int'(led_b), int'(m_led[2]));
    end
  end

  int upd_cnt;
  int hi_cnt;

  // Drive one edge worth of inputs; returns at the following negedge.
  task automatic cyc(input bit s, input bit i, input bit d, input bit r);
    sel_p = s; inc_p = i; dec_p = d; rstn = r;
    @(negedge clk);
    if (update) upd_cnt++;
  endtask

  task automatic count_led(input int ch, output int hi);
    hi = 0;
    for (int k = 0; k < PER; k++) begin
      cyc(0, 0, 0, 1);
      if ((ch == 0 && led_r) || (ch == 1 && led_g) || (ch == 2 && led_b)) hi++;
    end
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_sel", int'(sel_ch), 0);
    chk("rst_val", int'(ch_val), 8);
    chk("rst_upd", int'(update), 0);
    chk("rst_leds", int'({led_r, led_g, led_b}), 0);

    upd_cnt = 0;
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 1);
    chk("inc_sat_val", int'(ch_val), 15);
    chk("inc_upd_cnt", upd_cnt, 7);
    upd_cnt = 0;
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 1);
    chk("dec_sat_val", int'(ch_val), 0);
    chk("dec_upd_cnt", upd_cnt, 15);

    cyc(1, 0, 0, 1); chk("sel1", int'(sel_ch), 1); chk("sel1_upd", int'(update), 0);
    cyc(1, 0, 0, 1); chk("sel2", int'(sel_ch), 2);
    cyc(1, 0, 0, 1); chk("sel0", int'(sel_ch), 0);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    chk("selinc_sel", int'(sel_ch), 1);
    chk("selinc_upd", int'(update), 1);
    chk("selinc_g", int'(ch_val), 8);
    chk("selinc_r", int'(dut.r_val_r), 9);
    cyc(0, 1, 1, 1);
    chk("incdec_g", int'(ch_val), 8);
    chk("incdec_upd", int'(update), 0);

    // R: 9 -> 4, then 0, then 15.
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 1);
    count_led(0, hi_cnt); chk("pwm_r4", hi_cnt, 4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1);
    count_led(0, hi_cnt); chk("pwm_r0", hi_cnt, 0);
    for (int k = 0; k < 15; k++) cyc(0, 1, 0, 1);
    count_led(0, hi_cnt); chk("pwm_r15", hi_cnt, 15);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1);
    count_led(1, hi_cnt); chk("pwm_g4", hi_cnt, 4);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, 1);
    count_led(2, hi_cnt); chk("pwm_b15", hi_cnt, 15);

    for (int k = 0; k < 600; k++) begin
      cyc(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
          ($urandom % 60) != 0);
    end

    cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 0);
    chk("mid_rst_sel", int'(sel_ch), 0);
    chk("mid_rst_vals", int'(dut.r_val_r) + int'(dut.r_val_g) * 16 + int'(dut.r_val_b) * 256, 8 + 128 + 2048);
    chk("mid_rst_cnt", int'(dut.u_pwm.r_pwm_cnt), 0);
    chk("mid_rst_leds", int'({led_r, led_g, led_b}), 0);
    cyc(0, 0, 0, 1);
    chk("post_rst_leds", int'({led_r, led_g, led_b}), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
